// File: rtl/trim_sweep_gen_if.sv
// -----------------------------------------------------------------------------
// trim_sweep_gen_if
// Purpose : bundles the sequencer-facing control/status and the serial trim-bus
//           signals of trim_sweep_gen into one port.
// Signals : START, ABORT, MODE, CODE_INIT, CODE_END, STEP  (sequencer -> block)
//           ENCLK, DOUT, LATCH                             (block -> trim register)
//           TRIM_CODE, BUSY, DONE                          (block -> sequencer)
// Handshake: there is no valid/ready pair. A sweep is requested by a rising edge
//           on START while BUSY is low; the block answers with BUSY high on the
//           next cycle. The sweep has ended when BUSY falls with DONE high.
//           ABORT ends it at once with BUSY and DONE both low. CODE_INIT, CODE_END,
//           STEP and MODE only need to be valid in the cycle START rises.
// -----------------------------------------------------------------------------
interface trim_sweep_gen_if #(
    parameter int W = 12
);
    logic         START;
    logic         ABORT;
    logic [1:0]   MODE;
    logic [W-1:0] CODE_INIT;
    logic [W-1:0] CODE_END;
    logic [W-1:0] STEP;
    logic         ENCLK;
    logic         DOUT;
    logic         LATCH;
    logic [W-1:0] TRIM_CODE;
    logic         BUSY;
    logic         DONE;

    modport master (
        output START, ABORT, MODE, CODE_INIT, CODE_END, STEP,
        input  ENCLK, DOUT, LATCH, TRIM_CODE, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, MODE, CODE_INIT, CODE_END, STEP,
        output ENCLK, DOUT, LATCH, TRIM_CODE, BUSY, DONE
    );
endinterface

// File: rtl/trim_sweep_gen.sv
// -----------------------------------------------------------------------------
// trim_sweep_gen
// Purpose : steps a W-bit BGR trim code from CODE_INIT toward CODE_END by STEP.
//           Each code is shifted MSB-first on DOUT under a divided clock ENCLK.
//           It is then committed with a LATCH pulse and held for a dwell period.
// Optional: define TRIM_PARITY_EN to append an even-parity bit (XOR of the code)
//           after the LSB of every frame. If it is undefined, exactly W bits are sent.
// Ports   : CLK50       system clock, rising edge
//           RST         asynchronous active-high reset
//           bus         trim_sweep_gen_if.slave (control, status, serial trim bus)
//           dbg_state_o current FSM state (0 IDLE, 1 SHIFT, 2 LATCH, 3 DWELL, 4 DONE)
// -----------------------------------------------------------------------------
module trim_sweep_gen #(
    parameter int W         = 12,
    parameter int CLK_DIV   = 2,
    parameter int DWELL_CYC = 8
) (
    input  logic                CLK50,
    input  logic                RST,
    trim_sweep_gen_if.slave     bus,
    output logic [2:0]          dbg_state_o
);
`ifdef TRIM_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    localparam logic [15:0] BIT_LAST   = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] ENCLK_HI   = 16'(CLK_DIV);
    localparam logic [15:0] LATCH_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYC - 1);
    localparam logic [4:0]  NB_LAST    = 5'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_LATCH = 3'd2,
        S_DWELL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           start_prev_q;
    logic           up_q, up_d;
    logic           single_q, single_d;
    logic [W-1:0]   end_q, end_d;
    logic [W-1:0]   step_q, step_d;
    logic [W-1:0]   cur_q, cur_d;
    logic [W-1:0]   trim_q, trim_d;
    logic [NB-1:0]  shreg_q, shreg_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [4:0]     bit_q, bit_d;

    logic           start_edge;
    logic [W:0]     nxt_up, nxt_dn;
    logic [W-1:0]   nxt;
    logic           finish;

    // Frame image of one code: the code itself plus, optionally, its parity bit.
    function automatic logic [NB-1:0] frame_of(input logic [W-1:0] c);
`ifdef TRIM_PARITY_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

    // State register
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;   // START held high through reset must not launch
            up_q         <= 1'b0;
            single_q     <= 1'b1;
            end_q        <= '0;
            step_q       <= '0;
            cur_q        <= '0;
            trim_q       <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.START;
            up_q         <= up_d;
            single_q     <= single_d;
            end_q        <= end_d;
            step_q       <= step_d;
            cur_q        <= cur_d;
            trim_q       <= trim_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
        end
    end

    // The next code is formed in W+1 bits so an up-carry or down-borrow is visible
    // as "past the limit" instead of wrapping around to a legal-looking code.
    always_comb begin
        nxt_up = {1'b0, cur_q} + {1'b0, step_q};
        nxt_dn = {1'b0, cur_q} - {1'b0, step_q};
        finish = 1'b1;
        nxt    = nxt_dn[W-1:0];
        if (up_q) begin
            nxt = nxt_up[W-1:0];
        end
        if (!single_q) begin
            if (up_q) begin
                finish = (cur_q >= end_q) || (nxt_up > {1'b0, end_q});
            end else begin
                finish = (cur_q <= end_q) || nxt_dn[W] || (nxt_dn[W-1:0] < end_q);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        up_d       = up_q;
        single_d   = single_q;
        end_d      = end_q;
        step_d     = step_q;
        cur_d      = cur_q;
        trim_d     = trim_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        start_edge = bus.START && !start_prev_q;

        if (bus.ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state_d  = S_SHIFT;
                        up_d     = (bus.MODE == 2'd1);
                        single_d = (bus.MODE == 2'd0) || (bus.MODE == 2'd3) ||
                                   (bus.STEP == '0);
                        end_d    = bus.CODE_END;
                        step_d   = bus.STEP;
                        cur_d    = bus.CODE_INIT;
                        shreg_d  = frame_of(bus.CODE_INIT);
                        cnt_d    = '0;
                        bit_d    = '0;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        if (bit_q == NB_LAST) begin
                            state_d = S_LATCH;
                            trim_d  = cur_q;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shreg_d = shreg_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == LATCH_LAST) begin
                        state_d = S_DWELL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (finish) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                            cur_d   = nxt;
                            shreg_d = frame_of(nxt);
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode. The first half of each bit period is ENCLK low; the shift
    // register only moves at the bit boundary, so DOUT is steady while ENCLK is high.
    always_comb begin
        bus.ENCLK     = (state_q == S_SHIFT) && (cnt_q >= ENCLK_HI);
        bus.DOUT      = (state_q == S_SHIFT) && shreg_q[NB-1];
        bus.LATCH     = (state_q == S_LATCH);
        bus.BUSY      = (state_q == S_SHIFT) || (state_q == S_LATCH) ||
                        (state_q == S_DWELL);
        bus.DONE      = (state_q == S_DONE);
        bus.TRIM_CODE = trim_q;
        dbg_state_o   = state_q;
    end
endmodule

// File: tb/tb_trim_sweep_gen.sv
module tb_trim_sweep_gen;
    localparam int W         = 12;
    localparam int CLK_DIV   = 2;
    localparam int DWELL_CYC = 8;
`ifdef TRIM_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int FRAME = NB * 2 * CLK_DIV + CLK_DIV + DWELL_CYC;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    trim_sweep_gen_if #(.W(W)) bus ();

    trim_sweep_gen #(.W(W), .CLK_DIV(CLK_DIV), .DWELL_CYC(DWELL_CYC)) dut (
        .CLK50       (clk),
        .RST         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [NB-1:0] exp_q[$];
    int            latch_times[$];
    int            model_q[$];
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of codes a sweep must emit.
    task automatic build_model(input int mode, input int init, input int endc, input int step);
        int c;
        int n;
        model_q.delete();
        c = init;
        model_q.push_back(c);
        if (mode == 0 || mode == 3 || step == 0) return;
        forever begin
            if (mode == 1) begin
                n = c + step;
                if (c >= endc || n > endc) break;
            end else begin
                n = c - step;
                if (c <= endc || n < endc) break;
            end
            c = n;
            model_q.push_back(c);
        end
    endtask

    function automatic logic [NB-1:0] frame_word(input int c);
        logic [W-1:0] cw;
        cw = W'(c);
`ifdef TRIM_PARITY_EN
        return {cw, 1'($countones(cw) % 2)};
`else
        return cw;
`endif
    endfunction

    // ---------------- monitor ----------------
    int            cyc = 0;
    logic          prev_enclk = 1'b0;
    logic          prev_latch = 1'b0;
    logic [NB-1:0] word = '0;
    int            nbits = 0;
    int            lat_len = 0;

    always @(negedge clk) begin
        logic [NB-1:0] e;
        cyc++;
        if (rst || !bus.BUSY) begin
            nbits = 0;
        end
        if (!rst) begin
            if (bus.ENCLK && !prev_enclk) begin
                word  = {word[NB-2:0], bus.DOUT};
                nbits = nbits + 1;
            end
            if (bus.LATCH) lat_len = lat_len + 1;
            if (!bus.LATCH && prev_latch) begin
                check("latch_len", lat_len, CLK_DIV);
                lat_len = 0;
            end
            if (bus.LATCH && !prev_latch) begin
                latch_times.push_back(cyc);
                check("frame_bits", nbits, NB);
                nbits = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_latch: got frame %0h, expected no latch", word);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_word", word, e);
                    check("trim_code", bus.TRIM_CODE, e[NB-1 -: W]);
                end
            end
        end
        prev_enclk = bus.ENCLK;
        prev_latch = bus.LATCH;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic run_sweep(input int mode, input int init, input int endc, input int step,
                             input bit repulse);
        int lat0;
        int n;
        int bound;
        build_model(mode, init, endc, step);
        foreach (model_q[i]) exp_q.push_back(frame_word(model_q[i]));
        lat0 = latch_times.size();
        @(negedge clk);
        bus.MODE      = 2'(mode);
        bus.CODE_INIT = W'(init);
        bus.CODE_END  = W'(endc);
        bus.STEP      = W'(step);
        pulse_start();
        check("busy_after_start", bus.BUSY, 1);
        check("done_cleared", bus.DONE, 0);
        bound = (model_q.size() + 2) * FRAME;
        n = 0;
        while (!bus.DONE && n < bound) begin
            @(negedge clk);
            n++;
            if (repulse && n == 20) bus.START = 1'b1;
            if (repulse && n == 21) bus.START = 1'b0;
        end
        check("done_seen", bus.DONE, 1);
        check("busy_at_done", bus.BUSY, 0);
        check("trim_final", bus.TRIM_CODE, model_q[model_q.size()-1]);
        check("codes_left", exp_q.size(), 0);
        check("latch_count", latch_times.size() - lat0, model_q.size());
        for (int i = lat0 + 1; i < latch_times.size(); i++) begin
            check("frame_len", latch_times[i] - latch_times[i-1], FRAME);
        end
        exp_q.delete();
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int lat0;
        int n;
        int mode, init, endc, step, delta;
        rst           = 1'b1;
        bus.START     = 1'b1;
        bus.ABORT     = 1'b0;
        bus.MODE      = 2'd0;
        bus.CODE_INIT = '0;
        bus.CODE_END  = '0;
        bus.STEP      = '0;

        // Reset values
        #25;
        check("rst_enclk", bus.ENCLK, 0);
        check("rst_dout", bus.DOUT, 0);
        check("rst_latch", bus.LATCH, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_trim", bus.TRIM_CODE, 0);
        #25;
        rst = 1'b0;

        // START held high through reset release must not launch
        repeat (10) @(negedge clk);
        check("no_launch_held_start", bus.BUSY, 0);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);

        // Single code
        run_sweep(0, 'hA5C, 0, 0, 1'b0);
        // Sweep up, with a START re-pulse during BUSY that must be ignored
        run_sweep(1, 'h100, 'h104, 2, 1'b1);
        // Sweep down, no wrap below zero
        run_sweep(2, 'h003, 'h000, 2, 1'b0);
        // Sweep up near the top, no wrap above all-ones
        run_sweep(1, 'hFF0, 'hFFF, 8, 1'b0);
        // INIT already beyond limit, and mode 3 single
        run_sweep(1, 'h200, 'h100, 4, 1'b0);
        run_sweep(3, 'h001, 'h0FF, 1, 1'b0);

        // ABORT during bit 5 of the second code
        exp_q.push_back(frame_word('h100));
        lat0 = latch_times.size();
        bus.MODE      = 2'd1;
        bus.CODE_INIT = W'('h100);
        bus.CODE_END  = W'('h104);
        bus.STEP      = W'(2);
        pulse_start();
        n = 0;
        while (!bus.LATCH && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("first_latch_seen", bus.LATCH, 1);
        repeat (CLK_DIV + DWELL_CYC + 5 * 2 * CLK_DIV) @(negedge clk);
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        check("abort_busy", bus.BUSY, 0);
        check("abort_done", bus.DONE, 0);
        check("abort_enclk", bus.ENCLK, 0);
        check("abort_latch", bus.LATCH, 0);
        check("abort_trim", bus.TRIM_CODE, 'h100);
        repeat (2 * FRAME) @(negedge clk);
        check("abort_no_more_latch", latch_times.size() - lat0, 1);
        check("abort_codes_left", exp_q.size(), 0);
        exp_q.delete();
        run_sweep(1, 'h100, 'h104, 2, 1'b0);

        // ABORT and START in the same cycle: ABORT wins
        @(negedge clk);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        check("abort_beats_start", bus.BUSY, 0);
        bus.START = 1'b0;
        @(negedge clk);

        // Randomized sweeps
        for (int r = 0; r < 10; r++) begin
            mode  = $urandom_range(0, 3);
            init  = $urandom_range(0, (1 << W) - 1);
            delta = $urandom_range(0, 30);
            step  = $urandom_range(0, 12);
            if (mode == 2) endc = (init - delta < 0) ? 0 : init - delta;
            else endc = (init + delta > (1 << W) - 1) ? (1 << W) - 1 : init + delta;
            if ($urandom_range(0, 3) == 0) endc = $urandom_range(0, (1 << W) - 1);
            run_sweep(mode, init, endc, step, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
